// File: rtl/branch_ctrl.sv
// branch_ctrl: multicycle branch-resolution sequencer for an RV32I core.
// It accepts one B-type branch at a time, evaluates its condition over two
// cycles, and hands the resolved next PC to fetch over a valid/ready
// handshake. It also keeps saturating taken/total branch statistics.
//
// Ports:
//   clk, rst        clock (rising edge), async active-high reset
//   br_valid/ready  branch offer handshake (funct3, rs1, rs2, pc, imm)
//   res_valid/ready result handshake towards fetch
//   taken, pc_next  resolution result (qualified by res_valid)
//   illegal         funct3 was 010/011 (qualified by res_valid)
//   misaligned      taken target not word aligned (qualified by res_valid)
//   flush           combinational pulse during a taken, aligned handshake
//   cnt_total/taken saturating statistics counters
module branch_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             taken,
  output logic [XLEN-1:0]  pc_next,
  output logic             flush,
  output logic             illegal,
  output logic             misaligned,
  output logic [CNT_W-1:0] cnt_total,
  output logic [CNT_W-1:0] cnt_taken
);

  typedef enum logic [1:0] {IDLE, CMP, RESOLVE} state_t;

  typedef struct packed {
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
  } br_req_t;

  state_t          state, state_nxt;
  br_req_t         req;
  logic [2:0]      f3_q;
  logic            eq_q, lt_q, ltu_q;
  logic [XLEN-1:0] target_q, seq_q;
  logic            accept, hs, cond, redirect;

  assign accept = br_valid && br_ready;
  assign hs     = res_valid && res_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CMP;
      CMP:     state_nxt = RESOLVE;
      RESOLVE: if (hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    br_ready  = (state == IDLE);
    res_valid = (state == RESOLVE);
    flush     = hs && redirect;
  end

  // Condition decode from the registered compare results. All inputs here
  // are registers that only change on accept/CMP, so the result outputs stay
  // constant for the whole RESOLVE stall.
  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    case (f3_q)
      3'b000:  cond = eq_q;
      3'b001:  cond = !eq_q;
      3'b100:  cond = lt_q;
      3'b101:  cond = !lt_q;
      3'b110:  cond = ltu_q;
      3'b111:  cond = !ltu_q;
      default: illegal = 1'b1;
    endcase
    taken      = cond && !illegal;
    misaligned = taken && (target_q[1:0] != 2'b00);
    redirect   = taken && !misaligned;
    pc_next    = redirect ? target_q : seq_q;
  end

  // Request latch and compare stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req      <= '0;
      f3_q     <= '0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
      ltu_q    <= 1'b0;
      target_q <= '0;
      seq_q    <= '0;
    end else begin
      if (accept) req <= '{funct3, rs1, rs2, pc, imm};
      if (state == CMP) begin
        f3_q     <= req.funct3;
        eq_q     <= (req.rs1 == req.rs2);
        lt_q     <= ($signed(req.rs1) < $signed(req.rs2));
        ltu_q    <= (req.rs1 < req.rs2);
        target_q <= req.pc + req.imm;
        seq_q    <= req.pc + XLEN'(4);
      end
    end
  end

  // Statistics, updated on the result handshake, saturating at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_total <= '0;
      cnt_taken <= '0;
    end else if (hs) begin
      if (!illegal && (cnt_total != '1)) cnt_total <= cnt_total + 1'b1;
      if (redirect && (cnt_taken != '1)) cnt_taken <= cnt_taken + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             br_valid, br_ready;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  rs1, rs2, pc, imm;
  logic             res_valid, res_ready;
  logic             taken, flush, illegal, misaligned;
  logic [XLEN-1:0]  pc_next;
  logic [CNT_W-1:0] cnt_total, cnt_taken;

  int checks   = 0;
  int failures = 0;
  int m_total  = 0;
  int m_taken  = 0;

  always #5 clk = ~clk;

  branch_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_ready(br_ready),
    .funct3(funct3), .rs1(rs1), .rs2(rs2), .pc(pc), .imm(imm),
    .res_valid(res_valid), .res_ready(res_ready), .taken(taken),
    .pc_next(pc_next), .flush(flush), .illegal(illegal),
    .misaligned(misaligned), .cnt_total(cnt_total), .cnt_taken(cnt_taken)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Architectural meaning of an RV32I conditional branch.
  typedef struct {
    logic            ill, tk, mis;
    logic [XLEN-1:0] nxt;
  } res_t;

  function automatic res_t model(input logic [2:0] f, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b, input logic [XLEN-1:0] p,
                                 input logic [XLEN-1:0] i);
    res_t r;
    longint sa, sb;
    logic [XLEN-1:0] tgt;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r.ill = 1'b0;
    r.tk  = 1'b0;
    case (f)
      3'd0: r.tk = (a == b);
      3'd1: r.tk = (a != b);
      3'd4: r.tk = (sa < sb);
      3'd5: r.tk = (sa >= sb);
      3'd6: r.tk = (a < b);
      3'd7: r.tk = (a >= b);
      default: r.ill = 1'b1;
    endcase
    tgt   = XLEN'((longint'(p) + longint'(i)) % (64'd1 << XLEN));
    r.mis = r.tk && (tgt % 4 != 0);
    r.nxt = (r.tk && !r.mis) ? tgt : XLEN'(longint'(p) + 4);
    return r;
  endfunction

  task automatic chk_res(input string tag, input res_t e);
    chk({tag, ".res_valid"}, 64'(res_valid), 64'(1));
    chk({tag, ".taken"},     64'(taken),     64'(e.tk));
    chk({tag, ".illegal"},   64'(illegal),   64'(e.ill));
    chk({tag, ".misalign"},  64'(misaligned), 64'(e.mis));
    chk({tag, ".pc_next"},   64'(pc_next),   64'(e.nxt));
    chk({tag, ".br_ready"},  64'(br_ready),  64'(0));
  endtask

  // Offer one branch, hold the result for `stall` cycles, then consume it.
  // All driving and sampling happens on the falling edge.
  task automatic run_br(input string tag, input logic [2:0] f, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] p,
                        input logic [XLEN-1:0] i, input int stall);
    res_t e;
    e = model(f, a, b, p, i);
    @(negedge clk);
    chk({tag, ".idle_ready"}, 64'(br_ready), 64'(1));
    br_valid = 1'b1; funct3 = f; rs1 = a; rs2 = b; pc = p; imm = i;
    res_ready = 1'b0;
    @(negedge clk);                        // CMP cycle
    br_valid = 1'b0;
    funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom; pc = $urandom; imm = $urandom;
    chk({tag, ".cmp_valid"}, 64'(res_valid), 64'(0));
    chk({tag, ".cmp_ready"}, 64'(br_ready),  64'(0));
    @(negedge clk);                        // RESOLVE entry
    chk_res(tag, e);
    for (int k = 0; k < stall; k++) begin
      chk({tag, ".stall_flush"}, 64'(flush), 64'(0));
      @(negedge clk);
      chk_res({tag, ".hold"}, e);
    end
    res_ready = 1'b1;
    #1;
    chk({tag, ".flush"}, 64'(flush), 64'(e.tk && !e.mis));
    if (!e.ill && m_total < CMAX) m_total++;
    if (e.tk && !e.mis && m_taken < CMAX) m_taken++;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, ".done_valid"}, 64'(res_valid), 64'(0));
    chk({tag, ".done_ready"}, 64'(br_ready),  64'(1));
    chk({tag, ".done_flush"}, 64'(flush),     64'(0));
    chk({tag, ".cnt_total"},  64'(cnt_total), 64'(m_total));
    chk({tag, ".cnt_taken"},  64'(cnt_taken), 64'(m_taken));
  endtask

  initial begin
    logic [2:0]      rf;
    logic [XLEN-1:0] ra, rb, rp, ri;
    rst = 1'b1; br_valid = 1'b0; res_ready = 1'b0;
    funct3 = '0; rs1 = '0; rs2 = '0; pc = '0; imm = '0;
    #12;
    chk("rst.br_ready",  64'(br_ready),  64'(1));
    chk("rst.res_valid", 64'(res_valid), 64'(0));
    chk("rst.taken",     64'(taken),     64'(0));
    chk("rst.flush",     64'(flush),     64'(0));
    chk("rst.illegal",   64'(illegal),   64'(0));
    chk("rst.misalign",  64'(misaligned), 64'(0));
    chk("rst.pc_next",   64'(pc_next),   64'(0));
    chk("rst.cnt_total", 64'(cnt_total), 64'(0));
    chk("rst.cnt_taken", 64'(cnt_taken), 64'(0));
    @(negedge clk); rst = 1'b0;

    run_br("beq_taken", 3'b000, 5, 5, 32'h100, 32'h20, 0);
    run_br("blt",  3'b100, 32'hFFFF_FFFF, 1, 32'h200, 32'h10, 0);
    run_br("bltu", 3'b110, 32'hFFFF_FFFF, 1, 32'h200, 32'h10, 0);
    run_br("bgeu", 3'b111, 32'hFFFF_FFFF, 1, 32'h200, 32'h10, 0);
    run_br("bp5",  3'b001, 1, 2, 32'h300, 32'h40, 5);
    run_br("illegal010", 3'b010, 7, 7, 32'h400, 32'h8, 1);
    run_br("illegal011", 3'b011, 7, 8, 32'h400, 32'h8, 0);
    run_br("misalign", 3'b000, 3, 3, 32'h500, 32'h6, 2);
    run_br("wrap_tk",  3'b001, 1, 2, 32'hFFFF_FFFC, 32'h8, 0);
    run_br("wrap_nt",  3'b001, 2, 2, 32'hFFFF_FFFC, 32'h8, 0);
    run_br("neg_imm",  3'b101, 9, 2, 32'h1000, 32'hFFFF_FFF0, 0);

    // Reset while in CMP aborts the branch without flush or count.
    @(negedge clk);
    br_valid = 1'b1; funct3 = 3'b000; rs1 = 1; rs2 = 1; pc = 32'h40; imm = 32'h4;
    @(negedge clk);
    br_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstmid.br_ready",  64'(br_ready),  64'(1));
    chk("rstmid.res_valid", 64'(res_valid), 64'(0));
    chk("rstmid.flush",     64'(flush),     64'(0));
    chk("rstmid.cnt_total", 64'(cnt_total), 64'(0));
    chk("rstmid.cnt_taken", 64'(cnt_taken), 64'(0));
    m_total = 0; m_taken = 0;
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rstmid.no_valid", 64'(res_valid), 64'(0));
      chk("rstmid.ready",    64'(br_ready),  64'(1));
    end
    run_br("bge_eq", 3'b101, 32'h1234, 32'h1234, 32'h80, 32'h10, 0);

    // Random branches; enough taken ones to drive both counters into saturation.
    for (int n = 0; n < 60; n++) begin
      rf = 3'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) ra = $urandom;
      rb = ($urandom_range(0, 2) == 0) ? ra : $urandom;
      rp = $urandom & ~32'h3;
      ri = ($urandom_range(0, 4) == 0) ? $urandom : ($urandom & 32'h0000_1FFC);
      run_br("rand", rf, ra, rb, rp, ri, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
